// File: rtl/lock_key_if.sv
// Serial key-load handshake between the key source and lock_key_loader.
// The source drives start and the beat fields; the loader answers with key_ready.
interface lock_key_if;
  logic start;
  logic key_valid;
  logic key_bit;
  logic key_last;
  logic key_ready;

  modport master (
    output start, key_valid, key_bit, key_last,
    input  key_ready
  );

  modport slave (
    input  start, key_valid, key_bit, key_last,
    output key_ready
  );
endinterface

// File: rtl/lock_key_loader.sv
// Serial key loader for the logic-locked netlist key bus.
// Collects KEY_W data beats (LSB first) plus one even-parity beat, then commits
// the whole key to key_out in a single edge. Until that commit key_out carries
// the decoy. Each failed load costs one try; reaching MAX_TRIES locks the block
// out until reset.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | waiting for start after reset
//   LOAD    | accepting serial beats, key_ready high
//   CHECK   | one cycle: even parity over key bits plus parity beat
//   COMMIT  | one cycle: key_out takes the shift register
//   LOCKED  | good key committed, held until reset
//   ERROR   | failed attempt, retry allowed while tries < MAX_TRIES
//   LOCKOUT | retry budget spent, decoy held until reset
module lock_key_loader #(
  parameter int               KEY_W     = 32,
  parameter logic [KEY_W-1:0] DECOY     = '0,
  parameter int               MAX_TRIES = 3
) (
  input  logic             clk,
  input  logic             rst,
  lock_key_if.slave        bus,
  output logic [KEY_W-1:0] key_out,
  output logic             key_ok,
  output logic             err,
  output logic [3:0]       tries
);

  localparam int               CNT_W   = $clog2(KEY_W + 1);
  localparam logic [CNT_W-1:0] PAR_IDX = CNT_W'(KEY_W);
  localparam logic [3:0]       TRY_MAX = 4'(MAX_TRIES);
  localparam logic [KEY_W-1:0] ONE     = KEY_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    COMMIT,
    LOCKED,
    ERROR,
    LOCKOUT
  } state_t;

  state_t           state;
  logic [KEY_W-1:0] shreg;
  logic [CNT_W-1:0] count;
  logic             parity;
  logic             accept;
  logic             fail_now;

  assign bus.key_ready = (state == LOAD);
  assign accept        = bus.key_valid && bus.key_ready;

  // Any condition that ends the current attempt as a failure: framing on a
  // beat (last too early or missing on the parity beat) or odd parity.
  always_comb begin
    fail_now = 1'b0;
    case (state)
      LOAD: begin
        if (accept) begin
          fail_now = (count == PAR_IDX) ? !bus.key_last : bus.key_last;
        end
      end
      CHECK:   fail_now = (^shreg) ^ parity;
      default: fail_now = 1'b0;
    endcase
  end

  // Sequencer; key_out is only ever written in COMMIT or by reset so the
  // locked netlist never sees a partially loaded key.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      count   <= '0;
      parity  <= 1'b0;
      key_out <= DECOY;
      key_ok  <= 1'b0;
      err     <= 1'b0;
      tries   <= 4'd0;
    end else if (fail_now) begin
      state <= ERROR;
      shreg <= '0;
      err   <= 1'b1;
      if (tries != TRY_MAX) begin
        tries <= tries + 4'd1;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= LOAD;
            count <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (count == PAR_IDX) begin
              parity <= bus.key_bit;
              state  <= CHECK;
            end else begin
              shreg <= (shreg & ~(ONE << count)) | (KEY_W'(bus.key_bit) << count);
              count <= count + CNT_W'(1);
            end
          end
        end
        CHECK: state <= COMMIT;
        COMMIT: begin
          key_out <= shreg;
          key_ok  <= 1'b1;
          state   <= LOCKED;
        end
        ERROR: begin
          if (tries == TRY_MAX) begin
            state <= LOCKOUT;
          end else if (bus.start) begin
            state <= LOAD;
            err   <= 1'b0;
            count <= '0;
          end
        end
        LOCKED, LOCKOUT: begin
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lock_key_loader.sv
// Directed-plus-random bench for lock_key_loader. The reference model tracks
// only the externally visible result of each load attempt (committed key,
// ok/err flags, try count) derived from the framing and parity rules.
module tb_lock_key_loader;
  localparam int          KEY_W     = 32;
  localparam int          MAX_TRIES = 3;
  localparam logic [31:0] DECOY     = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] key_out;
  logic        key_ok;
  logic        err;
  logic [3:0]  tries;

  lock_key_if bus();

  lock_key_loader #(
    .KEY_W(KEY_W),
    .DECOY(DECOY),
    .MAX_TRIES(MAX_TRIES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .key_out(key_out),
    .key_ok(key_ok),
    .err(err),
    .tries(tries)
  );

  // 100 MHz style free-running clock
  always #5 clk = ~clk;

  // Watchdog so the run always terminates
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int errors = 0;

  // reference model of the visible result
  logic [31:0] m_key;
  bit          m_ok;
  bit          m_err;
  int          m_tries;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_key_out"}, key_out, m_key);
    chk({tag, "_key_ok"}, 32'(key_ok), 32'(m_ok));
    chk({tag, "_err"}, 32'(err), 32'(m_err));
    chk({tag, "_tries"}, 32'(tries), 32'(m_tries));
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    rst = 1'b1;
    repeat (ncyc) @(negedge clk);
    m_key   = DECOY;
    m_ok    = 1'b0;
    m_err   = 1'b0;
    m_tries = 0;
    chk_model("reset");
    chk("reset_ready", 32'(bus.key_ready), 32'd0);
    rst = 1'b0;
    bus.start     = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_bit   = 1'b0;
    bus.key_last  = 1'b0;
  endtask

  // one-cycle start pulse; ends on the negedge after the start edge
  task automatic do_start(input bit expect_load);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (expect_load) begin
      m_err = 1'b0;
      chk("start_ready", 32'(bus.key_ready), 32'd1);
      chk("start_err_clear", 32'(err), 32'd0);
    end
  endtask

  // drive nbeats accepted beats; beat KEY_W carries par; key_last on beat last_at
  task automatic send_beats(input logic [31:0] key, input logic par, input int last_at,
                            input int nbeats, input bit gaps);
    int   beat   = 0;
    int   budget = 0;
    logic accepted;
    while (beat < nbeats && budget < 2000) begin
      bus.key_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.key_bit   = (beat < KEY_W) ? key[beat] : par;
      bus.key_last  = (beat == last_at);
      accepted      = bus.key_valid && bus.key_ready;
      @(negedge clk);
      if (accepted) beat++;
      budget++;
    end
    bus.key_valid = 1'b0;
    bus.key_last  = 1'b0;
    bus.key_bit   = 1'b0;
    if (budget >= 2000) chk("beat_timeout", 32'(beat), 32'(nbeats));
  endtask

  // called on the negedge right after the edge that took the final beat
  task automatic finish_load(input string tag, input logic [31:0] key, input logic par,
                             input int last_at);
    bit good;
    good = (last_at == KEY_W) && (((^key) ^ par) == 1'b0);
    chk({tag, "_ready_low"}, 32'(bus.key_ready), 32'd0);
    chk({tag, "_hold0"}, key_out, m_key);
    @(negedge clk);
    chk({tag, "_hold1"}, key_out, m_key);
    @(negedge clk);
    if (good) begin
      m_key = key;
      m_ok  = 1'b1;
      m_err = 1'b0;
    end else begin
      m_err   = 1'b1;
      m_tries = (m_tries < MAX_TRIES) ? m_tries + 1 : MAX_TRIES;
    end
    chk_model(tag);
    @(negedge clk);
    chk_model({tag, "_settle"});
  endtask

  task automatic full_load(input string tag, input logic [31:0] key, input logic par,
                           input int last_at, input int nbeats, input bit gaps);
    do_start(1'b1);
    send_beats(key, par, last_at, nbeats, gaps);
    finish_load(tag, key, par, last_at);
  endtask

  // random beats/starts while the loader should not be accepting
  task automatic idle_noise(input string tag, input int ncyc, input bit with_start);
    for (int i = 0; i < ncyc; i++) begin
      bus.start     = with_start ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.key_valid = 1'b1;
      bus.key_bit   = 1'($urandom_range(0, 1));
      bus.key_last  = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk({tag, "_ready"}, 32'(bus.key_ready), 32'd0);
    end
    bus.start     = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_bit   = 1'b0;
    bus.key_last  = 1'b0;
    chk_model(tag);
  endtask

  logic [31:0] k;
  logic [31:0] k2;
  int          la;

  initial begin
    bus.start     = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_bit   = 1'b0;
    bus.key_last  = 1'b0;

    // 1: good load, no gaps
    do_reset(2);
    full_load("good", 32'hA5C3_0F96, 1'b0, KEY_W, KEY_W + 1, 1'b0);
    // LOCKED ignores start and beats
    idle_noise("locked", 40, 1'b1);

    // 2: IDLE noise then same key with random gaps
    do_reset(2);
    idle_noise("idle", 8, 1'b0);
    full_load("gaps", 32'hA5C3_0F96, 1'b0, KEY_W, KEY_W + 1, 1'b1);

    // 3: parity error then recovery with a random good key
    do_reset(2);
    full_load("par_err", 32'h0000_0001, 1'b0, KEY_W, KEY_W + 1, 1'b0);
    k = $urandom;
    full_load("recover", k, ^k, KEY_W, KEY_W + 1, 1'b1);

    // 4: framing errors
    do_reset(2);
    k = $urandom;
    full_load("early_last", k, ^k, 10, 11, 1'b0);
    k = $urandom;
    full_load("miss_last", k, ^k, -1, KEY_W + 1, 1'b1);

    // 5: three bad loads then lockout
    do_reset(2);
    k = $urandom;
    full_load("bad1", k, ~(^k), KEY_W, KEY_W + 1, 1'b1);
    k = $urandom;
    la = int'($urandom_range(0, KEY_W - 1));
    full_load("bad2", k, ^k, la, la + 1, 1'b0);
    k = $urandom;
    full_load("bad3", k, ^k, -1, KEY_W + 1, 1'b0);
    do_start(1'b0);
    idle_noise("lockout", 40, 1'b1);

    // 6: reset after 17 accepted beats, then a clean load
    do_reset(2);
    k = $urandom | 32'h0001_FFFF;
    do_start(1'b1);
    send_beats(k, 1'b0, -1, 17, 1'b1);
    do_reset(1);
    k2 = $urandom & 32'hFFFE_0000;
    full_load("post_abort", k2, ^k2, KEY_W, KEY_W + 1, 1'b1);

    // random good and bad attempts
    for (int n = 0; n < 4; n++) begin
      do_reset(2);
      k = $urandom;
      if (n[0]) full_load("rnd_bad", k, ~(^k), KEY_W, KEY_W + 1, 1'b1);
      k = $urandom;
      full_load("rnd_good", k, ^k, KEY_W, KEY_W + 1, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
